// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/decode/exec/mem/writeback sequencer, one instruction in flight.
// Define CORE_CTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret reads 0.
module core_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_alu,
    input  logic        illegal,
    input  logic        branch_taken,
    input  logic [4:0]  dest,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_en,
    output logic        alu_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        reg_w_en,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_JUMP    = 3'd4,
        C_ALU     = 3'd5
    } cls_t;

    state_t     state_r;
    logic [1:0] fault_r;
    logic [7:0] wait_cnt_r;
    cls_t       cls_s;
    logic       timeout_s;

    // Resolve instruction class by priority; no flag at all is treated as illegal
    always_comb begin
        if (illegal) begin
            cls_s = C_ILLEGAL;
        end else if (is_load) begin
            cls_s = C_LOAD;
        end else if (is_store) begin
            cls_s = C_STORE;
        end else if (is_branch) begin
            cls_s = C_BRANCH;
        end else if (is_jump) begin
            cls_s = C_JUMP;
        end else if (is_alu) begin
            cls_s = C_ALU;
        end else begin
            cls_s = C_ILLEGAL;
        end
    end

    // A ready arriving on the limit cycle is not a wait, so it wins over the timeout
    assign timeout_s = mem_req && !mem_ready && (wait_cnt_r == 8'(MEM_WAIT_MAX - 1));

    // Control outputs decoded from the current state and the live handshake/decoder inputs
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_en    = 1'b0;
        alu_en   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        reg_w_en = 1'b0;
        wb_sel   = 2'd0;
        halted   = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (cls_s == C_BRANCH) begin
                    pc_en  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                end else begin
                    pc_en  = 1'b0;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_s == C_STORE);
                pc_en    = mem_ready && (cls_s == C_STORE);
            end
            S_WB: begin
                reg_w_en = (dest != 5'd0);
                wb_sel   = (cls_s == C_LOAD) ? 2'd1 : ((cls_s == C_JUMP) ? 2'd2 : 2'd0);
                pc_en    = 1'b1;
                pc_sel   = (cls_s == C_JUMP) ? 2'd2 : 2'd0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Sequencer: state, sticky fault code and memory wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            fault_r    <= 2'd0;
            wait_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r    <= S_FETCH;
                    wait_cnt_r <= 8'd0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state_r <= S_DECODE;
                    end else if (timeout_s) begin
                        fault_r <= 2'd2;
                        state_r <= S_HALT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (cls_s == C_ILLEGAL) begin
                        fault_r <= 2'd1;
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt_r <= 8'd0;
                    case (cls_s)
                        C_LOAD, C_STORE: state_r <= S_MEM;
                        C_BRANCH:        state_r <= S_FETCH;
                        C_JUMP, C_ALU:   state_r <= S_WB;
                        default: begin
                            fault_r <= 2'd1;
                            state_r <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_r    <= (cls_s == C_STORE) ? S_FETCH : S_WB;
                        wait_cnt_r <= 8'd0;
                    end else if (timeout_s) begin
                        fault_r <= 2'd2;
                        state_r <= S_HALT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_WB: begin
                    state_r    <= S_FETCH;
                    wait_cnt_r <= 8'd0;
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign fault = fault_r;
    assign state = state_r;

`ifdef CORE_CTRL_INSTRET_EN
    logic        retire_s;
    logic [31:0] instret_r;

    assign retire_s = ((state_r == S_EXEC) && (cls_s == C_BRANCH)) ||
                      ((state_r == S_MEM) && mem_ready && (cls_s == C_STORE)) ||
                      (state_r == S_WB);

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_r <= 32'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized self-checking bench for core_ctrl: each instruction is expanded into its expected
// per-cycle output trace from the class rules, then played against the DUT cycle by cycle.
module tb_core_ctrl;
    localparam int MAX = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0, is_alu = 1'b0;
    logic        illegal = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
    logic [4:0]  dest = 5'd0;
    logic        mem_req, mem_we, addr_sel, ir_en, alu_en, pc_en, reg_w_en, halted;
    logic [1:0]  pc_sel, wb_sel, fault;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [16:0] obs;

    always #5 clk = ~clk;

    core_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .reset(reset), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jump(is_jump), .is_alu(is_alu), .illegal(illegal), .branch_taken(branch_taken),
        .dest(dest), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_en(ir_en), .alu_en(alu_en), .pc_en(pc_en), .pc_sel(pc_sel), .reg_w_en(reg_w_en),
        .wb_sel(wb_sel), .halted(halted), .fault(fault), .state(state), .instret(instret)
    );

    assign obs = {mem_req, mem_we, addr_sel, ir_en, alu_en, pc_en, pc_sel, reg_w_en, wb_sel,
                  halted, fault, state};

    typedef struct {
        logic        rdy;
        logic [16:0] v;
        logic        ret;
    } cyc_t;

    cyc_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] vec(input logic req, input logic we, input logic asel,
                                        input logic ir, input logic alu, input logic pce,
                                        input logic [1:0] psel, input logic rw, input logic [1:0] wsel,
                                        input logic hlt, input logic [1:0] flt, input logic [2:0] st);
        return {req, we, asel, ir, alu, pce, psel, rw, wsel, hlt, flt, st};
    endfunction

    task automatic push(input logic rdy, input logic [16:0] v, input logic ret);
        cyc_t c;
        c.rdy = rdy;
        c.v   = v;
        c.ret = ret;
        q.push_back(c);
    endtask

    task automatic halt_tail(input logic [1:0] flt, input int n);
        for (int i = 0; i < n; i++)
            push(1'($urandom_range(0, 1)), vec(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, flt, 3'd6), 1'b0);
    endtask

    // Flags are applied just after the first edge so the previous instruction's last cycle is untouched
    task automatic play(input string tag, input logic [4:0] fl, input logic ill, input logic [4:0] rd,
                        input logic tk);
        cyc_t c;
        bit   first = 1'b1;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            if (first) begin
                {is_load, is_store, is_branch, is_jump, is_alu} = fl;
                illegal = ill;
                dest = rd;
                branch_taken = tk;
                first = 1'b0;
            end
            mem_ready = c.rdy;
            @(negedge clk);
            check_eq({tag, "/out"}, 64'(obs), 64'(c.v));
            check_eq({tag, "/instret"}, 64'(instret), 64'(exp_instret));
`ifdef CORE_CTRL_INSTRET_EN
            if (c.ret) exp_instret = exp_instret + 32'd1;
`endif
        end
    endtask

    // fl = {load, store, branch, jump, alu}; delays >= MAX mean the memory never answers
    task automatic instr(input string tag, input logic [4:0] fl, input logic ill, input logic [4:0] rd,
                         input logic tk, input int fd, input int md, input int halt_n);
        int k;
        if (ill || fl == 5'd0) k = 0;
        else if (fl[4]) k = 1;
        else if (fl[3]) k = 2;
        else if (fl[2]) k = 3;
        else if (fl[1]) k = 4;
        else k = 5;
        if (fd >= MAX) begin
            for (int i = 0; i < MAX; i++)
                push(1'b0, vec(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd1), 1'b0);
            halt_tail(2'd2, halt_n);
        end else begin
            for (int i = 0; i <= fd; i++)
                push(i == fd, vec(1, 0, 0, i == fd, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd1), 1'b0);
            push(1'($urandom_range(0, 1)), vec(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd2), 1'b0);
            if (k == 0) begin
                halt_tail(2'd1, halt_n);
            end else begin
                push(1'($urandom_range(0, 1)),
                     vec(0, 0, 0, 0, 1, k == 3, (k == 3 && tk) ? 2'd1 : 2'd0, 0, 2'd0, 0, 2'd0, 3'd3),
                     k == 3);
                if ((k == 1 || k == 2) && md >= MAX) begin
                    for (int i = 0; i < MAX; i++)
                        push(1'b0, vec(1, k == 2, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd4), 1'b0);
                    halt_tail(2'd2, halt_n);
                end else begin
                    if (k == 1 || k == 2)
                        for (int i = 0; i <= md; i++)
                            push(i == md, vec(1, k == 2, 1, 0, 0, k == 2 && i == md, 2'd0, 0, 2'd0,
                                              0, 2'd0, 3'd4), k == 2 && i == md);
                    if (k == 1 || k == 4 || k == 5)
                        push(1'($urandom_range(0, 1)),
                             vec(0, 0, 0, 0, 0, 1, (k == 4) ? 2'd2 : 2'd0, rd != 5'd0,
                                 (k == 1) ? 2'd1 : ((k == 4) ? 2'd2 : 2'd0), 0, 2'd0, 3'd5), 1'b1);
                end
            end
        end
        play(tag, fl, ill, rd, tk);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ready = 1'b0;
        exp_instret = 32'd0;
        @(negedge clk);
        check_eq({tag, "/held"}, 64'({obs, instret}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq({tag, "/idle"}, 64'({obs, instret}), 64'(0));
    endtask

    initial begin
        int fd, md;
        logic [4:0] fl;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_state", 64'({obs, instret}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_state", 64'(obs), 64'(0));

        instr("addi_x3",   5'b00001, 1'b0, 5'd3, 1'b0, 0, 0, 0);
        instr("beq_taken", 5'b00100, 1'b0, 5'd7, 1'b1, 0, 0, 0);
        instr("beq_not",   5'b00100, 1'b0, 5'd7, 1'b0, 0, 0, 0);
        instr("lw_x5",     5'b10000, 1'b0, 5'd5, 1'b0, 0, 3, 0);
        instr("jal_x0",    5'b00010, 1'b0, 5'd0, 1'b0, 0, 0, 0);
        instr("sw",        5'b01000, 1'b0, 5'd9, 1'b0, 2, 1, 0);
        instr("prio_all",  5'b11111, 1'b0, 5'd4, 1'b1, 0, 0, 0);
        instr("fetch_lim", 5'b00001, 1'b0, 5'd1, 1'b0, MAX - 1, 0, 0);
        instr("mem_lim",   5'b01000, 1'b0, 5'd1, 1'b0, 0, MAX - 1, 0);
        instr("alu_x0",    5'b00001, 1'b0, 5'd0, 1'b0, 1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            fl = 5'($urandom_range(1, 31));
            fd = ($urandom_range(0, 9) == 0) ? MAX - 1 : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 9) == 0) ? MAX - 1 : int'($urandom_range(0, 3));
            instr("rand", fl, 1'b0, 5'($urandom), 1'($urandom), fd, md, 0);
        end

        // Reset asserted asynchronously in the middle of a fetch wait
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("mid_fetch", 64'(obs), 64'(vec(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd1)));
        #2;
        reset = 1'b1;
        exp_instret = 32'd0;
        #1;
        check_eq("async_rst", 64'({obs, instret}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("async_rel", 64'(obs), 64'(0));
        instr("after_rst", 5'b00001, 1'b0, 5'd2, 1'b0, 0, 0, 0);

        instr("mem_tmo",   5'b10000, 1'b0, 5'd6, 1'b0, 0, MAX, 8);
        do_reset("rst1");
        instr("addi_pre",  5'b00001, 1'b0, 5'd3, 1'b0, 0, 0, 0);
        instr("illegal",   5'b00001, 1'b1, 5'd3, 1'b0, 0, 0, 6);
        do_reset("rst2");
        instr("no_flag",   5'b00000, 1'b0, 5'd3, 1'b0, 1, 0, 4);
        do_reset("rst3");
        instr("fetch_tmo", 5'b00001, 1'b0, 5'd3, 1'b0, MAX, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
